// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: splits each 32-bit load/store into two 16-bit SRAM
// half-accesses and freezes the pipeline (ready = 0) while they are in flight.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int unsigned    CNT_W    = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [31:0]    BASE     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_wr_p0;
    logic [31:0]      wdata_p0;
    logic [31:0]      offset;
    logic             req, cnt_last, accept, busy, unused_bits;

    assign req         = rd_en | wr_en;
    assign cnt_last    = (cnt == CNT_LAST);
    assign accept      = (state == IDLE) && req;
    assign busy        = (state == LOW) || (state == HIGH);
    assign offset      = address - BASE;
    // Offset bits outside [18:2] are dropped: byte lanes and wrap-around.
    assign unused_bits = ^{offset[31:19], offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || !busy) cnt <= '0;
            else                             cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req)      state_nxt = LOW;
            LOW:  if (cnt_last) state_nxt = HIGH;
            HIGH: if (cnt_last) state_nxt = DONE;
            DONE:               state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Stage p0: request capture and SRAM address / read-word assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_p0  <= 1'b0;
            sram_addr <= '0;
            read_data <= '0;
        end else begin
            if (accept) begin
                op_wr_p0  <= wr_en;
                sram_addr <= {offset[18:2], 1'b0};
            end
            if (state == LOW && cnt_last) begin
                sram_addr[0] <= 1'b1;
                if (!op_wr_p0) read_data[15:0] <= sram_dq_in;
            end
            if (state == HIGH && cnt_last && !op_wr_p0)
                read_data[31:16] <= sram_dq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) wdata_p0 <= write_data;
    end

    // SRAM strobes are decoded from registered state only
    always_comb begin
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (op_wr_p0 && busy) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = (state == LOW) ? wdata_p0[15:0] : wdata_p0[31:16];
        end
    end

    assign ready = (state == DONE) || ((state == IDLE) && !req);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a 16-entry half-word SRAM model.
module tb_mem_stage_sram_ctrl;

    logic        clk, rst, rd_en, wr_en, ready, sram_dq_oe, sram_we_n, preload;
    logic [31:0] address, write_data, read_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic [15:0] mem [0:15];
    int          checks = 0;
    int          errors = 0;
    int          freeze;

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[4] <= 16'hBEEF;
            mem[5] <= 16'hDEAD;
        end else if (!sram_we_n) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0; preload = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got %b want 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b want 0", sram_dq_oe); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data got %h want 0", read_data); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL rst_addr got %h want 0", sram_addr); end
        checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL rst_dq_out got %h want 0", sram_dq_out); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'h0)
                begin errors++; $display("FAIL idle c%0d got rdy=%b we_n=%b oe=%b rd=%h want 1 1 0 0", c, ready, sram_we_n, sram_dq_oe, read_data); end
        end
    endtask

    task automatic test_read;
        rd_en = 1'b1; address = 32'd1032;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL read_c0_ready got %b want 0", ready); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (sram_addr !== ((c <= 2) ? 18'd4 : 18'd5))
                begin errors++; $display("FAIL read_addr c%0d got %0d want %0d", c, sram_addr, (c <= 2) ? 4 : 5); end
            checks++; if (ready !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
                begin errors++; $display("FAIL read_ctrl c%0d got rdy=%b we_n=%b oe=%b want 0 1 0", c, ready, sram_we_n, sram_dq_oe); end
        end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL read_done_ready got %b want 1", ready); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", read_data); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wr_c0_ready got %b want 0", ready); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (sram_addr !== ((c <= 2) ? 18'd0 : 18'd1))
                begin errors++; $display("FAIL wr_addr c%0d got %0d want %0d", c, sram_addr, (c <= 2) ? 0 : 1); end
            checks++; if (sram_dq_out !== ((c <= 2) ? 16'h5678 : 16'h1234))
                begin errors++; $display("FAIL wr_dq c%0d got %h want %h", c, sram_dq_out, (c <= 2) ? 16'h5678 : 16'h1234); end
            checks++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || ready !== 1'b0)
                begin errors++; $display("FAIL wr_ctrl c%0d got we_n=%b oe=%b rdy=%b want 0 1 0", c, sram_we_n, sram_dq_oe, ready); end
        end
        tick();
        checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_dq_out !== 16'h0)
            begin errors++; $display("FAIL wr_done got rdy=%b we_n=%b oe=%b dq=%h want 1 1 0 0", ready, sram_we_n, sram_dq_oe, sram_dq_out); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_keeps_rd got %h want deadbeef", read_data); end
        wr_en = 1'b0;
        tick();
        checks++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234)
            begin errors++; $display("FAIL wr_mem got %h %h want 5678 1234", mem[0], mem[1]); end
        rd_en = 1'b1;
        #1;
        repeat (5) tick();
        checks++; if (ready !== 1'b1 || read_data !== 32'h12345678)
            begin errors++; $display("FAIL wr_readback got rdy=%b rd=%h want 1 12345678", ready, read_data); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_both;
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1028; write_data = 32'hA5A5A5A5;
        #1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (sram_we_n !== 1'b0 || sram_dq_out !== 16'hA5A5 || sram_addr !== ((c <= 2) ? 18'd2 : 18'd3))
                begin errors++; $display("FAIL both c%0d got we_n=%b dq=%h addr=%0d want 0 a5a5 %0d", c, sram_we_n, sram_dq_out, sram_addr, (c <= 2) ? 2 : 3); end
        end
        tick();
        checks++; if (ready !== 1'b1 || read_data !== 32'h12345678)
            begin errors++; $display("FAIL both_done got rdy=%b rd=%h want 1 12345678", ready, read_data); end
        rd_en = 1'b0; wr_en = 1'b0;
        tick();
        checks++; if (mem[2] !== 16'hA5A5 || mem[3] !== 16'hA5A5)
            begin errors++; $display("FAIL both_mem got %h %h want a5a5 a5a5", mem[2], mem[3]); end
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b1; address = 32'd1024;
        #1;
        freeze = (ready === 1'b0) ? 1 : 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (ready === 1'b0) freeze++;
        end
        tick();
        checks++; if (ready !== 1'b1 || read_data !== 32'h12345678)
            begin errors++; $display("FAIL b2b_first got rdy=%b rd=%h want 1 12345678", ready, read_data); end
        checks++; if (freeze !== 5) begin errors++; $display("FAIL b2b_freeze1 got %0d want 5", freeze); end
        address = 32'd1028;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b want 0", ready); end
        freeze = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (ready === 1'b0) freeze++;
            checks++; if (sram_addr !== ((c <= 2) ? 18'd2 : 18'd3))
                begin errors++; $display("FAIL b2b_addr c%0d got %0d want %0d", c, sram_addr, (c <= 2) ? 2 : 3); end
        end
        tick();
        checks++; if (ready !== 1'b1 || read_data !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL b2b_second got rdy=%b rd=%h want 1 a5a5a5a5", ready, read_data); end
        checks++; if (freeze !== 5) begin errors++; $display("FAIL b2b_freeze2 got %0d want 5", freeze); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
        #1;
        repeat (3) tick();
        checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd1)
            begin errors++; $display("FAIL mid_pre got we_n=%b addr=%0d want 0 1", sram_we_n, sram_addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_dq_out !== 16'h0)
            begin errors++; $display("FAIL mid_strobes got we_n=%b oe=%b dq=%h want 1 0 0", sram_we_n, sram_dq_oe, sram_dq_out); end
        checks++; if (read_data !== 32'h0 || sram_addr !== 18'h0 || ready !== 1'b0)
            begin errors++; $display("FAIL mid_state got rd=%h addr=%0d rdy=%b want 0 0 0", read_data, sram_addr, ready); end
        wr_en = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_idle_ready got %b want 1", ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1)
                begin errors++; $display("FAIL mid_after c%0d got rdy=%b we_n=%b want 1 1", c, ready, sram_we_n); end
        end
        checks++; if (mem[0] !== 16'hF00D || mem[1] !== 16'h1234)
            begin errors++; $display("FAIL mid_mem got %h %h want f00d 1234", mem[0], mem[1]); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_both();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
